// File: rtl/hazard_controller_pkg.sv
// Shared definitions for the pipeline hazard controller: field widths,
// result-source and forwarding-select encodings, and the memory FSM states.
package hazard_controller_pkg;

  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned RES_SRC_W  = 2;
  localparam int unsigned FWD_SEL_W  = 2;
  localparam int unsigned PERF_CNT_W = 32;

  // Result source of the instruction in execute
  localparam logic [RES_SRC_W-1:0] RESULT_ALU = 2'b00;
  localparam logic [RES_SRC_W-1:0] RESULT_MEM = 2'b01;
  localparam logic [RES_SRC_W-1:0] RESULT_PC4 = 2'b10;

  // Operand forwarding selects
  localparam logic [FWD_SEL_W-1:0] FWD_NONE = 2'b00;
  localparam logic [FWD_SEL_W-1:0] FWD_W    = 2'b01;
  localparam logic [FWD_SEL_W-1:0] FWD_M    = 2'b10;

  // Data-memory handshake tracking
  typedef enum logic {
    IDLE     = 1'b0,
    MEM_WAIT = 1'b1
  } hazard_state_e;

endpackage

// File: rtl/hazard_mem_fsm.sv
// Tracks an outstanding data-memory access and flags the memory stall.
// Ports:
//   CLK, RST            clock, synchronous active-high reset
//   Mem_Req_M           data-memory access in the memory stage
//   Mem_Ack_M           data memory completes this cycle
//   mem_stall           memory stall condition, combinational (0 during RST)
module hazard_mem_fsm
  import hazard_controller_pkg::*;
(
  input  logic CLK,
  input  logic RST,
  input  logic Mem_Req_M,
  input  logic Mem_Ack_M,
  output logic mem_stall
);

  hazard_state_e state;

  // Enter MEM_WAIT on an unacknowledged request, leave on the ack
  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE:     if (Mem_Req_M && !Mem_Ack_M) state <= MEM_WAIT;
        MEM_WAIT: if (Mem_Ack_M)               state <= IDLE;
      endcase
    end
  end

  // Same-cycle stall; an ack in IDLE with or without a request never stalls
  assign mem_stall = !RST &&
                     (((state == IDLE) && Mem_Req_M && !Mem_Ack_M) ||
                      ((state == MEM_WAIT) && !Mem_Ack_M));

endmodule

// File: rtl/hazard_controller.sv
// Pipeline hazard controller: memory-wait stalls, branch flushes, load-use
// stalls and operand forwarding for a 5-stage pipeline.
// Priority: memory stall > branch flush > load-use stall.
// Optional: define HAZARD_PERF_CNT_EN to add the Stall_Cycles counter port.
// Ports:
//   CLK, RST                       clock, synchronous active-high reset
//   RS1_D, RS2_D                   decode source registers
//   RS1_E, RS2_E                   execute source registers
//   RD_E, RD_M, RD_W               destination registers per stage
//   Result_Src_Sel_E               result source in execute
//   REG_W_En_M, REG_W_En_W         register write enables
//   PC_Src_Sel_E                   branch/jump taken in execute
//   Mem_Req_M, Mem_Ack_M           data-memory handshake
//   Stall_F/D/E/M                  hold PC, IF/ID, ID/EX, EX/MEM
//   Flush_D/E                      clear IF/ID, ID/EX
//   Bubble_W                       kill the write-back enable at MEM/WB
//   Forward_A_E, Forward_B_E       operand forwarding selects
//   Stall_Cycles                   stall-cycle count (HAZARD_PERF_CNT_EN)
module hazard_controller
  import hazard_controller_pkg::*;
(
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [REG_ADDR_W-1:0] RS1_D,
  input  logic [REG_ADDR_W-1:0] RS2_D,
  input  logic [REG_ADDR_W-1:0] RS1_E,
  input  logic [REG_ADDR_W-1:0] RS2_E,
  input  logic [REG_ADDR_W-1:0] RD_E,
  input  logic [REG_ADDR_W-1:0] RD_M,
  input  logic [REG_ADDR_W-1:0] RD_W,
  input  logic [RES_SRC_W-1:0]  Result_Src_Sel_E,
  input  logic                  REG_W_En_M,
  input  logic                  REG_W_En_W,
  input  logic                  PC_Src_Sel_E,
  input  logic                  Mem_Req_M,
  input  logic                  Mem_Ack_M,
  output logic                  Stall_F,
  output logic                  Stall_D,
  output logic                  Stall_E,
  output logic                  Stall_M,
  output logic                  Flush_D,
  output logic                  Flush_E,
  output logic                  Bubble_W,
  output logic [FWD_SEL_W-1:0]  Forward_A_E,
  output logic [FWD_SEL_W-1:0]  Forward_B_E
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [PERF_CNT_W-1:0] Stall_Cycles
`endif
);

  logic mem_stall;
  logic load_use;

  hazard_mem_fsm u_mem_fsm (
    .CLK       (CLK),
    .RST       (RST),
    .Mem_Req_M (Mem_Req_M),
    .Mem_Ack_M (Mem_Ack_M),
    .mem_stall (mem_stall)
  );

  // Load in execute feeding a decode source; x0 never creates a hazard
  assign load_use = (Result_Src_Sel_E == RESULT_MEM) &&
                    (RD_E != '0) &&
                    ((RD_E == RS1_D) || (RD_E == RS2_D));

  // Stall/flush priority; reset parks the pipe in a flushed, bubbled state
  always_comb begin
    Stall_F  = 1'b0;
    Stall_D  = 1'b0;
    Stall_E  = 1'b0;
    Stall_M  = 1'b0;
    Flush_D  = 1'b0;
    Flush_E  = 1'b0;
    Bubble_W = 1'b0;
    if (RST) begin
      Flush_D  = 1'b1;
      Flush_E  = 1'b1;
      Bubble_W = 1'b1;
    end else if (mem_stall) begin
      Stall_F  = 1'b1;
      Stall_D  = 1'b1;
      Stall_E  = 1'b1;
      Stall_M  = 1'b1;
      Bubble_W = 1'b1;
    end else if (PC_Src_Sel_E) begin
      Flush_D = 1'b1;
      Flush_E = 1'b1;
    end else if (load_use) begin
      Stall_F = 1'b1;
      Stall_D = 1'b1;
      Flush_E = 1'b1;
    end
  end

  // Forwarding: the younger MEM-stage result wins over WB
  always_comb begin
    Forward_A_E = FWD_NONE;
    Forward_B_E = FWD_NONE;
    if (!RST) begin
      if (REG_W_En_M && (RD_M != '0) && (RD_M == RS1_E))      Forward_A_E = FWD_M;
      else if (REG_W_En_W && (RD_W != '0) && (RD_W == RS1_E)) Forward_A_E = FWD_W;
      if (REG_W_En_M && (RD_M != '0) && (RD_M == RS2_E))      Forward_B_E = FWD_M;
      else if (REG_W_En_W && (RD_W != '0) && (RD_W == RS2_E)) Forward_B_E = FWD_W;
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [PERF_CNT_W-1:0] stall_cnt_q;

  // Counts every cycle the front end is held; wraps naturally
  always_ff @(posedge CLK) begin
    if (RST) begin
      stall_cnt_q <= '0;
    end else if (Stall_F) begin
      stall_cnt_q <= stall_cnt_q + PERF_CNT_W'(1);
    end
  end

  assign Stall_Cycles = RST ? '0 : stall_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_controller.sv
// Self-checking bench for hazard_controller: directed vector table, hand
// sequences for multi-cycle cases, and randomized stimulus against a model.
// Define HAZARD_PERF_CNT_EN to also exercise Stall_Cycles.
module tb_hazard_controller;

  typedef struct packed {
    logic [4:0] rs1_d;
    logic [4:0] rs2_d;
    logic [4:0] rs1_e;
    logic [4:0] rs2_e;
    logic [4:0] rd_e;
    logic [4:0] rd_m;
    logic [4:0] rd_w;
    logic [1:0] res_src;
    logic       wen_m;
    logic       wen_w;
    logic       pc_src;
    logic       req;
    logic       ack;
    logic [3:0] e_stall;   // {F, D, E, M}
    logic [1:0] e_flush;   // {D, E}
    logic       e_bubble;
    logic [1:0] e_fa;
    logic [1:0] e_fb;
  } vec_t;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic [4:0] RS1_D = '0, RS2_D = '0, RS1_E = '0, RS2_E = '0;
  logic [4:0] RD_E = '0, RD_M = '0, RD_W = '0;
  logic [1:0] Result_Src_Sel_E = '0;
  logic       REG_W_En_M = 1'b0, REG_W_En_W = 1'b0, PC_Src_Sel_E = 1'b0;
  logic       Mem_Req_M = 1'b0, Mem_Ack_M = 1'b0;
  logic       Stall_F, Stall_D, Stall_E, Stall_M, Flush_D, Flush_E, Bubble_W;
  logic [1:0] Forward_A_E, Forward_B_E;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] Stall_Cycles;
`endif

  int checks = 0;
  int errors = 0;

  hazard_controller dut (
    .CLK              (CLK),
    .RST              (RST),
    .RS1_D            (RS1_D),
    .RS2_D            (RS2_D),
    .RS1_E            (RS1_E),
    .RS2_E            (RS2_E),
    .RD_E             (RD_E),
    .RD_M             (RD_M),
    .RD_W             (RD_W),
    .Result_Src_Sel_E (Result_Src_Sel_E),
    .REG_W_En_M       (REG_W_En_M),
    .REG_W_En_W       (REG_W_En_W),
    .PC_Src_Sel_E     (PC_Src_Sel_E),
    .Mem_Req_M        (Mem_Req_M),
    .Mem_Ack_M        (Mem_Ack_M),
    .Stall_F          (Stall_F),
    .Stall_D          (Stall_D),
    .Stall_E          (Stall_E),
    .Stall_M          (Stall_M),
    .Flush_D          (Flush_D),
    .Flush_E          (Flush_E),
    .Bubble_W         (Bubble_W),
    .Forward_A_E      (Forward_A_E),
    .Forward_B_E      (Forward_B_E)
`ifdef HAZARD_PERF_CNT_EN
    ,
    .Stall_Cycles     (Stall_Cycles)
`endif
  );

  always #5 CLK = ~CLK;

  // Reference model state: is a memory access still awaiting its ack?
  vec_t        cur_v = '0;
  logic        cur_rst = 1'b1;
  logic        m_waiting = 1'b0;
  logic [31:0] m_cnt = '0;

  function automatic logic [1:0] fwd_of(logic [4:0] rs, vec_t v);
    if (v.wen_m && v.rd_m != 0 && v.rd_m == rs) return 2'b10;
    if (v.wen_w && v.rd_w != 0 && v.rd_w == rs) return 2'b01;
    return 2'b00;
  endfunction

  function automatic vec_t exp_of(vec_t v, logic waiting, logic rst);
    vec_t e;
    logic ms, lu;
    e  = v;
    ms = (waiting || v.req) && !v.ack;
    lu = v.res_src == 2'b01 && v.rd_e != 0 && (v.rd_e == v.rs1_d || v.rd_e == v.rs2_d);
    if (rst) begin
      e.e_stall = 4'b0000; e.e_flush = 2'b11; e.e_bubble = 1'b1;
      e.e_fa = 2'b00; e.e_fb = 2'b00;
    end else begin
      e.e_fa = fwd_of(v.rs1_e, v);
      e.e_fb = fwd_of(v.rs2_e, v);
      if (ms)            begin e.e_stall = 4'b1111; e.e_flush = 2'b00; e.e_bubble = 1'b1; end
      else if (v.pc_src) begin e.e_stall = 4'b0000; e.e_flush = 2'b11; e.e_bubble = 1'b0; end
      else if (lu)       begin e.e_stall = 4'b1100; e.e_flush = 2'b01; e.e_bubble = 1'b0; end
      else               begin e.e_stall = 4'b0000; e.e_flush = 2'b00; e.e_bubble = 1'b0; end
    end
    return e;
  endfunction

  always @(posedge CLK) begin
    vec_t e;
    e = exp_of(cur_v, m_waiting, cur_rst);
    if (cur_rst) begin
      m_waiting <= 1'b0;
      m_cnt     <= '0;
    end else begin
      m_waiting <= (m_waiting || cur_v.req) && !cur_v.ack;
      if (e.e_stall[3]) m_cnt <= m_cnt + 32'd1;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Drive one cycle, compare mid-cycle, then advance past the clock edge
  task automatic run_vec(input vec_t v, input logic rst, input string name);
    cur_v = v; cur_rst = rst; RST = rst;
    RS1_D = v.rs1_d; RS2_D = v.rs2_d; RS1_E = v.rs1_e; RS2_E = v.rs2_e;
    RD_E = v.rd_e; RD_M = v.rd_m; RD_W = v.rd_w; Result_Src_Sel_E = v.res_src;
    REG_W_En_M = v.wen_m; REG_W_En_W = v.wen_w; PC_Src_Sel_E = v.pc_src;
    Mem_Req_M = v.req; Mem_Ack_M = v.ack;
    #2;
    chk({name, ".stall"},  32'({Stall_F, Stall_D, Stall_E, Stall_M}), 32'(v.e_stall));
    chk({name, ".flush"},  32'({Flush_D, Flush_E}), 32'(v.e_flush));
    chk({name, ".bubble"}, 32'(Bubble_W), 32'(v.e_bubble));
    chk({name, ".fwd_a"},  32'(Forward_A_E), 32'(v.e_fa));
    chk({name, ".fwd_b"},  32'(Forward_B_E), 32'(v.e_fb));
`ifdef HAZARD_PERF_CNT_EN
    chk({name, ".stall_cycles"}, Stall_Cycles, rst ? 32'd0 : m_cnt);
`endif
    @(posedge CLK);
    #1;
  endtask

  vec_t tbl [12];
  vec_t v;
  vec_t rst_v;

  initial begin
    // Directed table, all applied from IDLE
    tbl[0]  = '{res_src:2'b01, rd_e:5'd5, rs1_d:5'd5, e_stall:4'b1100, e_flush:2'b01, default:'0};
    tbl[1]  = '{res_src:2'b01, rd_e:5'd0, rs1_d:5'd0, default:'0};
    tbl[2]  = '{res_src:2'b01, rd_e:5'd9, rs2_d:5'd9, e_stall:4'b1100, e_flush:2'b01, default:'0};
    tbl[3]  = '{res_src:2'b00, rd_e:5'd5, rs1_d:5'd5, default:'0};
    tbl[4]  = '{pc_src:1'b1, res_src:2'b01, rd_e:5'd5, rs1_d:5'd5, e_flush:2'b11, default:'0};
    tbl[5]  = '{rd_m:5'd7, rd_w:5'd7, wen_m:1'b1, wen_w:1'b1, rs1_e:5'd7, e_fa:2'b10, default:'0};
    tbl[6]  = '{rd_m:5'd7, rd_w:5'd7, wen_m:1'b0, wen_w:1'b1, rs1_e:5'd7, e_fa:2'b01, default:'0};
    tbl[7]  = '{rd_m:5'd7, rd_w:5'd7, wen_m:1'b1, wen_w:1'b1, rs1_e:5'd0, default:'0};
    tbl[8]  = '{rd_m:5'd0, rd_w:5'd0, wen_m:1'b1, wen_w:1'b1, rs1_e:5'd0, rs2_e:5'd0, default:'0};
    tbl[9]  = '{rd_m:5'd3, rd_w:5'd4, wen_m:1'b1, wen_w:1'b1, rs1_e:5'd4, rs2_e:5'd3,
                e_fa:2'b01, e_fb:2'b10, default:'0};
    tbl[10] = '{ack:1'b1, default:'0};                       // ack without request
    tbl[11] = '{req:1'b1, ack:1'b1, default:'0};             // request acked at once
    rst_v   = '{e_flush:2'b11, e_bubble:1'b1, default:'0};

    run_vec(rst_v, 1'b1, "reset0");
    run_vec(rst_v, 1'b1, "reset1");
    for (int i = 0; i < 12; i++) run_vec(tbl[i], 1'b0, $sformatf("tbl%0d", i));
    run_vec('0, 1'b0, "idle_after_req_ack");

    // Three-cycle memory wait; flush and load-use suppressed while waiting
    run_vec('{req:1'b1, e_stall:4'b1111, e_bubble:1'b1, default:'0}, 1'b0, "mw1");
    run_vec('{req:1'b1, pc_src:1'b1, res_src:2'b01, rd_e:5'd5, rs1_d:5'd5,
              e_stall:4'b1111, e_bubble:1'b1, default:'0}, 1'b0, "mw2_suppress");
    run_vec('{req:1'b1, e_stall:4'b1111, e_bubble:1'b1, default:'0}, 1'b0, "mw3");
    run_vec('{req:1'b1, ack:1'b1, default:'0}, 1'b0, "mw_ack");
    run_vec('0, 1'b0, "mw_idle");

    // Reset while waiting: reset outputs, then back in IDLE regardless of ack
    run_vec('{req:1'b1, e_stall:4'b1111, e_bubble:1'b1, default:'0}, 1'b0, "rw_enter");
    run_vec('{req:1'b1, rd_m:5'd7, wen_m:1'b1, rs1_e:5'd7, pc_src:1'b1,
              e_flush:2'b11, e_bubble:1'b1, default:'0}, 1'b1, "rw_reset");
    run_vec('0, 1'b0, "rw_idle");

`ifdef HAZARD_PERF_CNT_EN
    // 3 memory-stall cycles plus 1 load-use cycle after reset
    run_vec(rst_v, 1'b1, "perf_rst");
    for (int i = 0; i < 3; i++)
      run_vec('{req:1'b1, e_stall:4'b1111, e_bubble:1'b1, default:'0}, 1'b0, "perf_mw");
    run_vec('{ack:1'b1, req:1'b1, default:'0}, 1'b0, "perf_ack");
    run_vec('{res_src:2'b01, rd_e:5'd5, rs1_d:5'd5, e_stall:4'b1100, e_flush:2'b01,
              default:'0}, 1'b0, "perf_lu");
    #2;
    chk("perf.total", Stall_Cycles, 32'd4);
    @(posedge CLK); #1;
`endif

    // Randomized cycles against the reference model
    for (int i = 0; i < 400; i++) begin
      logic r;
      v = '0;
      v.rs1_d = 5'($urandom_range(0, 3)); v.rs2_d = 5'($urandom_range(0, 3));
      v.rs1_e = 5'($urandom_range(0, 3)); v.rs2_e = 5'($urandom_range(0, 3));
      v.rd_e  = 5'($urandom_range(0, 3)); v.rd_m  = 5'($urandom_range(0, 3));
      v.rd_w  = 5'($urandom_range(0, 3)); v.res_src = 2'($urandom_range(0, 3));
      v.wen_m = 1'($urandom); v.wen_w = 1'($urandom);
      v.pc_src = ($urandom_range(0, 3) == 0);
      v.req = ($urandom_range(0, 2) == 0);
      v.ack = ($urandom_range(0, 2) == 0);
      r = ($urandom_range(0, 49) == 0);
      run_vec(exp_of(v, m_waiting, r), r, $sformatf("rand%0d", i));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
